// File: rtl/fir_xifu_pkg.sv
// Shared types for the X-interface scoreboard: per-slot state encoding and
// the status bundle (issued/committed/killed vectors) consumed by EX and WB.
package fir_xifu_pkg;

    // Upper bound on tracked IDs; status vectors are sized to this.
    localparam int unsigned MAX_ID = 16;

    typedef enum logic [1:0] {
        SLOT_FREE      = 2'd0,
        SLOT_ISSUED    = 2'd1,
        SLOT_COMMITTED = 2'd2,
        SLOT_KILLED    = 2'd3
    } slot_state_e;

    typedef struct packed {
        logic [MAX_ID-1:0] issued;
        logic [MAX_ID-1:0] committed;
        logic [MAX_ID-1:0] killed;
    } sb_status_t;

    // A slot whose commit decision is known and is waiting for writeback.
    function automatic logic is_resolved(slot_state_e s);
        return (s == SLOT_COMMITTED) || (s == SLOT_KILLED);
    endfunction

endpackage

// File: rtl/fir_xifu_scoreboard_if.sv
// Issue/commit handshake between decode/core (master) and the scoreboard
// (slave). Signal names keep the scoreboard-side direction suffixes.
interface fir_xifu_scoreboard_if #(
    parameter int unsigned ID_W = 2
) ();

    logic            issue_valid_i;
    logic [ID_W-1:0] issue_id_i;
    logic            issue_ready_o;
    logic            commit_valid_i;
    logic [ID_W-1:0] commit_id_i;
    logic            commit_kill_i;

    modport master (
        output issue_valid_i, issue_id_i,
        output commit_valid_i, commit_id_i, commit_kill_i,
        input  issue_ready_o
    );

    modport slave (
        input  issue_valid_i, issue_id_i,
        input  commit_valid_i, commit_id_i, commit_kill_i,
        output issue_ready_o
    );

endinterface

// File: rtl/fir_xifu_scoreboard_slot.sv
// One scoreboard entry: FREE -> ISSUED -> COMMITTED/KILLED -> FREE.
// Clear has priority over issue and commit; illegal requests are ignored
// and reported on err for the sticky flag in the top.
module fir_xifu_scoreboard_slot
    import fir_xifu_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        issue,       // accepted issue addressed to this slot
    input  logic        commit,      // (filtered) commit addressed to this slot
    input  logic        kill,
    input  logic        clear,
    output slot_state_e state,
    output slot_state_e state_next,
    output logic        err
);

    // State register.
    // NOTE: asynchronous active-low reset lives in the sensitivity list so the
    // slot drops to FREE without waiting for a clock edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= SLOT_FREE;
        end else begin
            // NOTE: non-blocking assignment for flops; blocking here would
            // make simulation order-dependent against other always_ff blocks.
            state <= state_next;
        end
    end

    // Next-state and per-cycle error decode.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no
        // latch is inferred.
        state_next = state;
        err        = 1'b0;
        if (clear) begin
            if (is_resolved(state)) begin
                state_next = SLOT_FREE;
            end else begin
                err = 1'b1;
            end
        end else begin
            // issue is only ever asserted while the slot is FREE.
            if (issue) begin
                state_next = SLOT_ISSUED;
            end
            if (commit) begin
                if (issue || (state != SLOT_ISSUED)) begin
                    err = 1'b1;
                end else begin
                    state_next = kill ? SLOT_KILLED : SLOT_COMMITTED;
                end
            end
        end
    end

endmodule

// File: rtl/fir_xifu_scoreboard.sv
// X-interface instruction scoreboard: tracks NUM_ID in-flight IDs from issue
// through commit/kill to writeback retirement. Holds the per-ID slots, the
// outstanding counter, the sticky protocol-error flag and the optional
// duplicate-commit filter enabled by FIR_XIFU_SCOREBOARD_DUPFILT_EN.
module fir_xifu_scoreboard
    import fir_xifu_pkg::*;
#(
    parameter  int unsigned NUM_ID = 4,
    parameter  int unsigned ID_W   = (NUM_ID > 1) ? $clog2(NUM_ID) : 1,
    localparam int unsigned CNT_W  = $clog2(NUM_ID + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    fir_xifu_scoreboard_if.slave  xif,
    input  logic [NUM_ID-1:0]     clear_i,
    output logic [NUM_ID-1:0]     issued_o,
    output logic [NUM_ID-1:0]     committed_o,
    output logic [NUM_ID-1:0]     killed_o,
    output logic [CNT_W-1:0]      outstanding_o,
    output logic                  full_o,
    output logic                  err_o
);

    slot_state_e       slot_state      [NUM_ID];
    slot_state_e       slot_state_next [NUM_ID];
    logic [NUM_ID-1:0] slot_err;
    logic              issue_ready;
    logic              issue_accept;
    logic              commit_eff;
    logic              commit_oob;
    logic [CNT_W-1:0]  count_next;
    logic [CNT_W-1:0]  count_q;
    logic              full_q;
    logic              err_q;
    sb_status_t        status;

`ifdef FIR_XIFU_SCOREBOARD_DUPFILT_EN
    logic            prev_commit_valid;
    logic [ID_W-1:0] prev_commit_id;

    // Remember last cycle's commit so a repeated strobe can be discarded.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_commit_valid <= 1'b0;
            prev_commit_id    <= '0;
        end else begin
            prev_commit_valid <= xif.commit_valid_i;
            prev_commit_id    <= xif.commit_id_i;
        end
    end

    assign commit_eff = xif.commit_valid_i &
                        ~(prev_commit_valid && (prev_commit_id == xif.commit_id_i));
`else
    assign commit_eff = xif.commit_valid_i;
`endif

    // Ready reflects only the addressed slot's current state; IDs beyond
    // NUM_ID are never ready.
    always_comb begin
        issue_ready = 1'b0;
        for (int i = 0; i < int'(NUM_ID); i++) begin
            if (xif.issue_id_i == ID_W'(i)) begin
                issue_ready = (slot_state[i] == SLOT_FREE);
            end
        end
    end

    assign xif.issue_ready_o = issue_ready;
    assign issue_accept      = xif.issue_valid_i & issue_ready;
    assign commit_oob        = commit_eff && (32'(xif.commit_id_i) >= NUM_ID);

    for (genvar g = 0; g < int'(NUM_ID); g++) begin : g_slot
        fir_xifu_scoreboard_slot u_slot (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .issue      (issue_accept && (xif.issue_id_i == ID_W'(g))),
            .commit     (commit_eff && (xif.commit_id_i == ID_W'(g))),
            .kill       (xif.commit_kill_i),
            .clear      (clear_i[g]),
            .state      (slot_state[g]),
            .state_next (slot_state_next[g]),
            .err        (slot_err[g])
        );
    end

    // Occupancy after this edge, so the registered count lines up with the
    // slot flags that become visible in the same cycle.
    always_comb begin
        count_next = '0;
        for (int i = 0; i < int'(NUM_ID); i++) begin
            if (slot_state_next[i] != SLOT_FREE) begin
                count_next = count_next + CNT_W'(1);
            end
        end
    end

    // Outstanding count, full flag and sticky error register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_next;
            full_q  <= (count_next == CNT_W'(NUM_ID));
            err_q   <= err_q | (|slot_err) | commit_oob;
        end
    end

    // Decode registered slot states into the status bundle.
    always_comb begin
        status = '0;
        for (int i = 0; i < int'(NUM_ID); i++) begin
            status.issued[i]    = (slot_state[i] != SLOT_FREE);
            status.committed[i] = is_resolved(slot_state[i]);
            status.killed[i]    = (slot_state[i] == SLOT_KILLED);
        end
    end

    assign issued_o      = status.issued[NUM_ID-1:0];
    assign committed_o   = status.committed[NUM_ID-1:0];
    assign killed_o      = status.killed[NUM_ID-1:0];
    assign outstanding_o = count_q;
    assign full_o        = full_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_fir_xifu_scoreboard.sv
// Scoreboard bench for fir_xifu_scoreboard (NUM_ID=4). The driver applies one
// stimulus per cycle, advances a behavioural model and queues the expected
// ready/flags; an independent monitor pops and compares. Honours
// FIR_XIFU_SCOREBOARD_DUPFILT_EN in the model.
module tb_fir_xifu_scoreboard;

    localparam int NUM_ID = 4;
    localparam int ID_W   = 2;
    localparam int CNT_W  = 3;

    localparam int ST_FREE = 0;
    localparam int ST_ISS  = 1;
    localparam int ST_COM  = 2;
    localparam int ST_KIL  = 3;

    typedef struct {
        logic       ready;
        logic [3:0] iss;
        logic [3:0] com;
        logic [3:0] kil;
        int         outs;
        logic       full;
        logic       err;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [3:0]       clear;
    logic [3:0]       issued, committed, killed;
    logic [CNT_W-1:0] outstanding;
    logic             full, err;

    fir_xifu_scoreboard_if #(.ID_W(ID_W)) xif ();

    fir_xifu_scoreboard #(.NUM_ID(NUM_ID)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .xif           (xif.slave),
        .clear_i       (clear),
        .issued_o      (issued),
        .committed_o   (committed),
        .killed_o      (killed),
        .outstanding_o (outstanding),
        .full_o        (full),
        .err_o         (err)
    );

    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_bad = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    // Behavioural model: slot states, sticky error, last-cycle commit.
    int st [NUM_ID];
    bit m_err;
    bit prev_cv;
    int prev_cid;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_ID; i++) st[i] = ST_FREE;
        m_err    = 1'b0;
        prev_cv  = 1'b0;
        prev_cid = 0;
    endtask

    // One cycle of stimulus; the model result is queued for the monitor.
    task automatic step(bit iv, int iid, bit cv, int cid, bit ck, logic [3:0] clr);
        exp_t e;
        bit   acc;
        bit   ce;
        int   nst [NUM_ID];
        int   cnt;
        @(negedge clk);
        xif.issue_valid_i  = iv;
        xif.issue_id_i     = iid[ID_W-1:0];
        xif.commit_valid_i = cv;
        xif.commit_id_i    = cid[ID_W-1:0];
        xif.commit_kill_i  = ck;
        clear              = clr;
        #1;
        e.ready = (st[iid] == ST_FREE);
        acc     = iv && e.ready;
        ce      = cv;
`ifdef FIR_XIFU_SCOREBOARD_DUPFILT_EN
        if (prev_cv && prev_cid == cid) ce = 1'b0;
`endif
        prev_cv  = cv;
        prev_cid = cid;
        nst = st;
        for (int i = 0; i < NUM_ID; i++) begin
            if (clr[i]) begin
                if (st[i] == ST_COM || st[i] == ST_KIL) nst[i] = ST_FREE;
                else m_err = 1'b1;
            end
        end
        if (acc && !clr[iid]) nst[iid] = ST_ISS;
        if (ce && !clr[cid]) begin
            if ((acc && iid == cid) || st[cid] != ST_ISS) m_err = 1'b1;
            else nst[cid] = ck ? ST_KIL : ST_COM;
        end
        st  = nst;
        cnt = 0;
        for (int i = 0; i < NUM_ID; i++) begin
            e.iss[i] = (st[i] != ST_FREE);
            e.com[i] = (st[i] == ST_COM || st[i] == ST_KIL);
            e.kil[i] = (st[i] == ST_KIL);
            if (st[i] != ST_FREE) cnt++;
        end
        e.outs = cnt;
        e.full = (cnt == NUM_ID);
        e.err  = m_err;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        step(1'b0, 0, 1'b0, 0, 1'b0, 4'b0000);
    endtask

    // Asynchronous reset mid-cycle; outputs must clear before any clock edge.
    task automatic do_reset();
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        #3;
        rst_n              = 1'b0;
        xif.issue_valid_i  = 1'b0;
        xif.commit_valid_i = 1'b0;
        xif.commit_kill_i  = 1'b0;
        clear              = 4'b0000;
        #1;
        check("rst_issued",      32'(issued),      32'd0);
        check("rst_committed",   32'(committed),   32'd0);
        check("rst_killed",      32'(killed),      32'd0);
        check("rst_outstanding", 32'(outstanding), 32'd0);
        check("rst_full",        32'(full),        32'd0);
        check("rst_err",         32'(err),         32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: ready before the edge, registered flags after it.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("issue_ready", 32'(xif.issue_ready_o), 32'(mon_e.ready));
                @(posedge clk);
                #1;
                check("issued",      32'(issued),      32'(mon_e.iss));
                check("committed",   32'(committed),   32'(mon_e.com));
                check("killed",      32'(killed),      32'(mon_e.kil));
                check("outstanding", 32'(outstanding), 32'(mon_e.outs));
                check("full",        32'(full),        32'(mon_e.full));
                check("err",         32'(err),         32'(mon_e.err));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        xif.issue_valid_i  = 1'b0;
        xif.issue_id_i     = '0;
        xif.commit_valid_i = 1'b0;
        xif.commit_id_i    = '0;
        xif.commit_kill_i  = 1'b0;
        clear              = 4'b0000;
        model_reset();
        do_reset();

        // Issue 2, commit 2 two cycles later, then retire it.
        step(1, 2, 0, 0, 0, 4'b0000);
        idle();
        step(0, 0, 1, 2, 0, 4'b0000);
        step(0, 0, 0, 0, 0, 4'b0100);
        idle();
        do_reset();

        // Fill all slots; re-issue of a busy ID stalls.
        for (int i = 0; i < NUM_ID; i++) step(1, i, 0, 0, 0, 4'b0000);
        step(1, 1, 0, 0, 0, 4'b0000);
        idle();
        do_reset();

        // Kill path and retirement of a killed slot.
        step(1, 3, 0, 0, 0, 4'b0000);
        step(0, 0, 1, 3, 1, 4'b0000);
        step(0, 0, 0, 0, 0, 4'b1000);
        idle();
        do_reset();

        // Commit to a FREE slot raises the sticky error.
        step(0, 0, 1, 1, 0, 4'b0000);
        idle();
        idle();
        do_reset();

        // Back-to-back commits of the same ID.
        step(1, 0, 0, 0, 0, 4'b0000);
        step(0, 0, 1, 0, 0, 4'b0000);
        step(0, 0, 1, 0, 0, 4'b0000);
        idle();
        do_reset();

        // Issue, commit and clear on distinct IDs in one cycle.
        step(1, 0, 0, 0, 0, 4'b0000);
        step(1, 2, 0, 0, 0, 4'b0000);
        step(0, 0, 1, 2, 0, 4'b0000);
        step(1, 1, 1, 0, 0, 4'b0100);
        idle();
        do_reset();

        // Same-cycle issue and commit of one ID is an error.
        step(1, 1, 1, 1, 0, 4'b0000);
        idle();
        do_reset();

        // Reset with IDs in flight.
        step(1, 0, 0, 0, 0, 4'b0000);
        step(1, 1, 1, 0, 1, 4'b0000);
        step(0, 0, 0, 0, 0, 4'b0010);
        do_reset();
        idle();

        // Randomised traffic with periodic resets.
        for (int n = 0; n < 600; n++) begin
            logic [3:0] clr;
            clr = 4'b0000;
            if ($urandom_range(0, 2) == 0) clr[$urandom_range(0, 3)] = 1'b1;
            step($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)),
                 $urandom_range(0, 2) == 0, int'($urandom_range(0, 3)),
                 $urandom_range(0, 1) == 1, clr);
            if (n % 60 == 59) do_reset();
        end

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
        @(negedge clk);
        check("final_queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
